result_queue_multi_unloader: RTL and testbench

//  Parametrised successor of the single-queue result unloader.

---
 rtl/result_queue_multi_unloader.sv | 124 ++++++++++++
 tb/tb_result_queue_multi_unloader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_queue_multi_unloader.sv
// rtl/result_queue_multi_unloader.sv - round-robin unloader of NUM_CH result queues onto one ready/wanted port
// Optional data_ch source tag enabled by defining RQU_CHAN_TAG_EN.
module result_queue_multi_unloader #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    data_wanted,
    output logic                    data_ready,
    output logic [WIDTH-1:0]        data,
`ifdef RQU_CHAN_TAG_EN
    output logic [CH_W-1:0]         data_ch,
`endif
    output logic                    busy,
    input  logic [NUM_CH-1:0]       rq_empty,
    input  logic [NUM_CH*WIDTH-1:0] rq_q,
    output logic [NUM_CH-1:0]       rq_re
);

    typedef enum logic [1:0] {
        S_Idle    = 2'd0,
        S_Pop     = 2'd1,
        S_Capture = 2'd2,
        S_Send    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]  data_q, data_d;
`ifdef RQU_CHAN_TAG_EN
    logic [CH_W-1:0]   data_ch_q, data_ch_d;
`endif

    logic              any_req;
    logic              found;
    logic [CH_W-1:0]   next_grant;

    // grant_q doubles as last_grant: it changes only when a new grant is taken
    always_comb begin
        any_req    = |(~rq_empty);
        found      = 1'b0;
        next_grant = grant_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!found && !rq_empty[(int'(grant_q) + i) % NUM_CH]) begin
                found      = 1'b1;
                next_grant = CH_W'((int'(grant_q) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
`ifdef RQU_CHAN_TAG_EN
        data_ch_d = data_ch_q;
`endif
        case (state_q)
            S_Idle: begin
                if (any_req) begin
                    grant_d = next_grant;
                    state_d = S_Pop;
                end
            end
            S_Pop: begin
                state_d = S_Capture;
            end
            S_Capture: begin
                data_d  = rq_q[int'(grant_q)*WIDTH +: WIDTH];
`ifdef RQU_CHAN_TAG_EN
                data_ch_d = grant_q;
`endif
                state_d = S_Send;
            end
            S_Send: begin
                if (data_wanted) begin
                    if (any_req) begin
                        grant_d = next_grant;
                        state_d = S_Pop;
                    end else begin
                        state_d = S_Idle;
                    end
                end
            end
            default: state_d = S_Idle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_Idle;
            grant_q <= CH_W'(NUM_CH - 1);
            data_q  <= '0;
`ifdef RQU_CHAN_TAG_EN
            data_ch_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
`ifdef RQU_CHAN_TAG_EN
            data_ch_q <= data_ch_d;
`endif
        end
    end

    // Strobes decode straight from the state flop so reset clears them at once
    always_comb begin
        rq_re = '0;
        if (state_q == S_Pop) begin
            rq_re[grant_q] = 1'b1;
        end
    end

    assign data_ready = (state_q == S_Send);
    assign busy       = (state_q != S_Idle);
    assign data       = data_q;
`ifdef RQU_CHAN_TAG_EN
    assign data_ch    = data_ch_q;
`endif

endmodule

// File: tb/tb_result_queue_multi_unloader.sv
// tb/tb_result_queue_multi_unloader.sv - directed vector bench for result_queue_multi_unloader
module tb_result_queue_multi_unloader;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         data_wanted = 1'b0;
    logic         data_ready;
    logic         busy;
    logic [31:0]  data;
`ifdef RQU_CHAN_TAG_EN
    logic [1:0]   data_ch;
`endif
    logic [3:0]   rq_empty;
    logic [127:0] rq_q;
    logic [3:0]   rq_re;

    int total = 0;
    int bad   = 0;

    result_queue_multi_unloader #(.WIDTH(32), .NUM_CH(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .data_wanted (data_wanted),
        .data_ready  (data_ready),
        .data        (data),
`ifdef RQU_CHAN_TAG_EN
        .data_ch     (data_ch),
`endif
        .busy        (busy),
        .rq_empty    (rq_empty),
        .rq_q        (rq_q),
        .rq_re       (rq_re)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO model per channel
    logic [31:0] mem [4][16];
    int          wr_cnt [4] = '{default: 0};
    int          rd_ptr [4] = '{default: 0};
    logic [31:0] rd_q   [4] = '{default: 32'h0};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rq_re[i]) begin
                rd_q[i]   <= mem[i][rd_ptr[i] % 16];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        rq_empty = '0;
        rq_q     = '0;
        for (int i = 0; i < 4; i++) begin
            rq_empty[i]      = (rd_ptr[i] == wr_cnt[i]);
            rq_q[i*32 +: 32] = rd_q[i];
        end
    end

    task automatic push(input int ch, input logic [7:0] tag);
        mem[ch][wr_cnt[ch] % 16] = {16'hA5A5, tag, 8'(ch)};
        wr_cnt[ch] = wr_cnt[ch] + 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [31:0] exp_q[$];

    task automatic collect(input int n);
        int got = 0;
        int last_t = 0;
        int cyc = 0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (data_ready) begin
                chk("data", data, exp_q[got]);
`ifdef RQU_CHAN_TAG_EN
                chk("data_ch", 32'(data_ch), 32'(exp_q[got][1:0]));
`endif
                if (got > 0) chk("word_gap", 32'(cyc - last_t), 32'd3);
                last_t = cyc;
                got++;
            end
        end
        chk("word_count", 32'(got), 32'(n));
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("return_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0] mask;
        int         n;
        logic [7:0] ord;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc;
        logic [31:0] held;

        vecs[0] = '{4'b1111, 4, {2'd2, 2'd1, 2'd0, 2'd3}};
        vecs[1] = '{4'b0011, 2, {2'd0, 2'd0, 2'd1, 2'd0}};
        vecs[2] = '{4'b1001, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[3] = '{4'b0001, 1, {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[4] = '{4'b1010, 2, {2'd0, 2'd0, 2'd3, 2'd1}};
        vecs[5] = '{4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}};

        // Reset and idle with all queues empty
        #1;
        chk("rst_rq_re", 32'(rq_re), 32'd0);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", data, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_rq_re", 32'(rq_re), 32'd0);
            chk("idle_ready", 32'(data_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Single word on ch2: pop one cycle later, data_ready two after that
        push(2, 8'h00);
        data_wanted = 1'b1;
        @(negedge clk);
        chk("lat_rq_re", 32'(rq_re), 32'b0100);
        chk("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("lat_rq_re_off", 32'(rq_re), 32'd0);
        chk("lat_ready_early", 32'(data_ready), 32'd0);
        @(negedge clk);
        chk("lat_ready", 32'(data_ready), 32'd1);
        chk("lat_data", data, 32'hA5A5_0002);
`ifdef RQU_CHAN_TAG_EN
        chk("lat_data_ch", 32'(data_ch), 32'd2);
`endif
        @(negedge clk);
        chk("lat_idle", 32'(busy), 32'd0);

        // Round-robin vectors; last grant carries over between vectors
        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < 4; c++) begin
                if (vecs[v].mask[c]) push(c, 8'(v + 1));
            end
            exp_q.delete();
            for (int k = 0; k < vecs[v].n; k++) begin
                exp_q.push_back({16'hA5A5, 8'(v + 1), 6'd0, vecs[v].ord[2*k +: 2]});
            end
            collect(vecs[v].n);
        end

        // Consumer stall: word held, no further pops
        data_wanted = 1'b0;
        push(1, 8'h40);
        push(3, 8'h40);
        cyc = 0;
        while (!data_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_ready", 32'(data_ready), 32'd1);
        chk("stall_first", data, 32'hA5A5_4003);
        held = data;
        repeat (10) begin
            @(negedge clk);
            chk("stall_hold_ready", 32'(data_ready), 32'd1);
            chk("stall_hold_data", data, held);
            chk("stall_no_pop", 32'(rq_re), 32'd0);
        end
        data_wanted = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'hA5A5_4001);
        collect(1);

        // Reset right after a pop of ch1; the popped word is dropped
        push(1, 8'h1E);
        cyc = 0;
        while (rq_re != 4'b0010 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_rst_pop", 32'(rq_re), 32'b0010);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_rq_re", 32'(rq_re), 32'd0);
        chk("arst_ready", 32'(data_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_data", data, 32'd0);
        @(negedge clk);
        for (int c = 0; c < 4; c++) push(c, 8'h1F);
        push(0, 8'h20);
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'hA5A5_1F00);
        exp_q.push_back(32'hA5A5_1F01);
        exp_q.push_back(32'hA5A5_1F02);
        exp_q.push_back(32'hA5A5_1F03);
        exp_q.push_back(32'hA5A5_2000);
        collect(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
